// File: rtl/pong_pkg.sv
// Shared Pong types: FSM states, default playfield geometry and direction encoding.
package pong_pkg;

  localparam int FIELD_W = 16;
  localparam int FIELD_H = 16;
  localparam int PAD_H   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // One bit per axis: NEG is left / up, POS is right / down.
  localparam logic DIR_NEG = 1'b0;
  localparam logic DIR_POS = 1'b1;

endpackage

// File: rtl/pong_move_timer.sv
// Edge-detects the 100 Hz divider output into one-cycle ticks and divides ticks into ball steps.
module pong_move_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_100Hz,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             step
);

  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign tick   = clk_100Hz & ~prev;
  // >= rather than == so a period shrinking under a running count still wraps.
  assign at_end = (cnt >= period - 1'b1);
  assign step   = tick & at_end & ~clr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= 1'b1;
      cnt  <= '0;
    end else begin
      prev <= clk_100Hz;
      if (clr)
        cnt <= '0;
      else if (tick)
        cnt <= at_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball motion, bounce, paddle collision and scoring FSM for Pong.
// Optional PONG_BALL_SPEEDUP_EN: step period shrinks by one per paddle hit down to MIN_DIV.
module pong_ball_ctrl #(
  parameter int FIELD_W    = pong_pkg::FIELD_W,
  parameter int FIELD_H    = pong_pkg::FIELD_H,
  parameter int PAD_H      = pong_pkg::PAD_H,
  parameter int MOVE_DIV   = 10,
  parameter int MIN_DIV    = 3,
  parameter int HOLD_TICKS = 100,
  parameter int WIN_SCORE  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_100Hz,
  input  logic                         start,
  input  logic [$clog2(FIELD_H)-1:0]   paddle_l_y,
  input  logic [$clog2(FIELD_H)-1:0]   paddle_r_y,
  output logic [$clog2(FIELD_W)-1:0]   ball_x,
  output logic [$clog2(FIELD_H)-1:0]   ball_y,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_l,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_r,
  output logic                         point_l,
  output logic                         point_r,
  output logic                         game_over
);
  import pong_pkg::*;

  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  localparam int SW = $clog2(WIN_SCORE+1);
  localparam int PW = $clog2(MOVE_DIV+1);
  localparam int HW = $clog2(HOLD_TICKS);

  localparam logic [XW-1:0] X_MID    = XW'(FIELD_W/2);
  localparam logic [XW-1:0] X_LO     = XW'(1);
  localparam logic [XW-1:0] X_HI     = XW'(FIELD_W-2);
  localparam logic [YW-1:0] Y_MID    = YW'(FIELD_H/2);
  localparam logic [YW-1:0] Y_BOT    = YW'(FIELD_H-1);
  localparam logic [YW-1:0] PAD_MAX  = YW'(FIELD_H-PAD_H);
  localparam logic [SW-1:0] S_WIN    = SW'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS-1);

  if (MIN_DIV < 1 || MIN_DIV > MOVE_DIV) begin : g_bad_div
    $error("pong_ball_ctrl: MIN_DIV must be in 1..MOVE_DIV");
  end

  state_t        state;
  logic          dx, dy, ndy;
  logic [YW-1:0] pl, pr, ny;
  logic [HW-1:0] hold_cnt;
  logic          tick, step, clr, move, win, at_left, at_right, hit_l, hit_r;
  logic [PW-1:0] period;

  assign win       = (score_l == S_WIN) || (score_r == S_WIN);
  assign move      = step && (state == ST_SERVE || state == ST_PLAY);
  assign at_left   = (dx == DIR_NEG) && (ball_x == X_LO);
  assign at_right  = (dx == DIR_POS) && (ball_x == X_HI);
  assign game_over = (state == ST_OVER);

  always_comb begin
    pl  = (paddle_l_y > PAD_MAX) ? PAD_MAX : paddle_l_y;
    pr  = (paddle_r_y > PAD_MAX) ? PAD_MAX : paddle_r_y;
    ndy = dy;
    if (dy == DIR_POS) begin
      if (ball_y == Y_BOT) begin
        ny  = Y_BOT - 1'b1;
        ndy = DIR_NEG;
      end else
        ny = ball_y + 1'b1;
    end else begin
      if (ball_y == '0) begin
        ny  = YW'(1);
        ndy = DIR_POS;
      end else
        ny = ball_y - 1'b1;
    end
    hit_l = (int'(ny) >= int'(pl)) && (int'(ny) <= int'(pl) + PAD_H - 1);
    hit_r = (int'(ny) >= int'(pr)) && (int'(ny) <= int'(pr) + PAD_H - 1);
  end

  // Step counter and ball placement restart together on every entry to SERVE.
  always_comb begin
    clr = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: clr = start;
      ST_SCORED:        clr = tick && (hold_cnt == HOLD_END) && !win;
      default:          clr = 1'b0;
    endcase
  end

`ifdef PONG_BALL_SPEEDUP_EN
  logic paddle_hit;
  assign paddle_hit = move && ((at_left && hit_l) || (at_right && hit_r));

  always_ff @(posedge clk) begin
    if (!rst)
      period <= PW'(MOVE_DIV);
    else if (clr)
      period <= PW'(MOVE_DIV);
    else if (paddle_hit && period > PW'(MIN_DIV))
      period <= period - 1'b1;
  end
`else
  assign period = PW'(MOVE_DIV);
`endif

  pong_move_timer #(.CNT_W(PW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clk_100Hz (clk_100Hz),
    .clr       (clr),
    .period    (period),
    .tick      (tick),
    .step      (step)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ball_x   <= X_MID;
      ball_y   <= Y_MID;
      dx       <= DIR_NEG;
      dy       <= DIR_POS;
      score_l  <= '0;
      score_r  <= '0;
      point_l  <= 1'b0;
      point_r  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: if (start) begin
          state   <= ST_SERVE;
          score_l <= '0;
          score_r <= '0;
          dx      <= DIR_NEG;
        end
        ST_SERVE: if (step) state <= ST_PLAY;
        ST_SCORED: if (tick) begin
          if (hold_cnt == HOLD_END) begin
            hold_cnt <= '0;
            state    <= win ? ST_OVER : ST_SERVE;
          end else
            hold_cnt <= hold_cnt + 1'b1;
        end
        default: ;
      endcase

      // dx is left alone on serve after a point: it already points at the conceding side.
      if (clr) begin
        ball_x <= X_MID;
        ball_y <= Y_MID;
        dy     <= DIR_POS;
      end

      if (move) begin
        if (at_left && !hit_l) begin
          score_r  <= (score_r == S_WIN) ? S_WIN : score_r + 1'b1;
          point_r  <= 1'b1;
          state    <= ST_SCORED;
          hold_cnt <= '0;
        end else if (at_right && !hit_r) begin
          score_l  <= (score_l == S_WIN) ? S_WIN : score_l + 1'b1;
          point_l  <= 1'b1;
          state    <= ST_SCORED;
          hold_cnt <= '0;
        end else begin
          ball_y <= ny;
          dy     <= ndy;
          if (at_left) begin
            ball_x <= X_LO + 1'b1;
            dx     <= DIR_POS;
          end else if (at_right) begin
            ball_x <= X_HI - 1'b1;
            dx     <= DIR_NEG;
          end else
            ball_x <= (dx == DIR_POS) ? ball_x + 1'b1 : ball_x - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: serve, bounces, paddle hits, misses, win and reset.
module tb_pong_ball_ctrl;
  logic       clk, rst, clk_100Hz, start;
  logic [3:0] paddle_l_y, paddle_r_y;
  logic [3:0] ball_x, ball_y;
  logic [2:0] score_l, score_r;
  logic       point_l, point_r, game_over;
  int checks, errors;

  pong_ball_ctrl dut (
    .clk(clk), .rst(rst), .clk_100Hz(clk_100Hz), .start(start),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // One rising edge of clk_100Hz per iteration; returns on a falling clk edge after the update.
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) clk_100Hz = 1'b1;
      @(negedge clk) clk_100Hz = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL reset_ball got (%0d,%0d) want (8,8)", ball_x, ball_y); end
    checks++; if ({score_l, score_r, point_l, point_r, game_over} !== 9'b0) begin errors++; $display("FAIL reset_outs got sl=%0d sr=%0d pl=%b pr=%b go=%b want all 0", score_l, score_r, point_l, point_r, game_over); end
    rst = 1'b1;
    pulse(15);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL idle_frozen got (%0d,%0d) want (8,8)", ball_x, ball_y); end
  endtask

  task automatic test_serve();
    paddle_l_y = 4'd15;
    paddle_r_y = 4'd0;
    press_start();
    pulse(9);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL serve_wait got (%0d,%0d) want (8,8)", ball_x, ball_y); end
    pulse(1);
    checks++; if ({ball_x, ball_y} !== {4'd7, 4'd9}) begin errors++; $display("FAIL serve_step got (%0d,%0d) want (7,9)", ball_x, ball_y); end
  endtask

  task automatic test_rally();
    pulse(60);
    checks++; if ({ball_x, ball_y} !== {4'd1, 4'd15}) begin errors++; $display("FAIL rally_corner got (%0d,%0d) want (1,15)", ball_x, ball_y); end
    // bottom wall bounce plus left hit against a clamped paddle (15 -> 13)
    pulse(10);
    checks++; if ({ball_x, ball_y} !== {4'd2, 4'd14}) begin errors++; $display("FAIL left_hit got (%0d,%0d) want (2,14)", ball_x, ball_y); end
    checks++; if ({score_l, score_r} !== 6'd0) begin errors++; $display("FAIL left_hit_score got %0d/%0d want 0/0", score_l, score_r); end
    press_start();
    pulse(120);
    checks++; if ({ball_x, ball_y} !== {4'd14, 4'd2}) begin errors++; $display("FAIL right_approach got (%0d,%0d) want (14,2)", ball_x, ball_y); end
    pulse(10);
    checks++; if ({ball_x, ball_y} !== {4'd13, 4'd1}) begin errors++; $display("FAIL right_hit got (%0d,%0d) want (13,1)", ball_x, ball_y); end
    pulse(20);
    checks++; if ({ball_x, ball_y} !== {4'd11, 4'd1}) begin errors++; $display("FAIL top_bounce got (%0d,%0d) want (11,1)", ball_x, ball_y); end
  endtask

  task automatic test_miss_left();
    paddle_l_y = 4'd0;
    pulse(100);
    checks++; if ({ball_x, ball_y} !== {4'd1, 4'd11}) begin errors++; $display("FAIL left_approach got (%0d,%0d) want (1,11)", ball_x, ball_y); end
    pulse(10);
    checks++; if ({score_l, score_r, point_r, point_l} !== {3'd0, 3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL miss_left got sl=%0d sr=%0d pr=%b pl=%b want 0 1 1 0", score_l, score_r, point_r, point_l); end
    checks++; if ({ball_x, ball_y} !== {4'd1, 4'd11}) begin errors++; $display("FAIL miss_left_frozen got (%0d,%0d) want (1,11)", ball_x, ball_y); end
    @(negedge clk);
    checks++; if (point_r !== 1'b0) begin errors++; $display("FAIL point_r_width got %b want 0", point_r); end
    pulse(99);
    checks++; if ({ball_x, ball_y} !== {4'd1, 4'd11}) begin errors++; $display("FAIL hold_99 got (%0d,%0d) want (1,11)", ball_x, ball_y); end
    pulse(1);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL hold_done got (%0d,%0d) want (8,8)", ball_x, ball_y); end
    paddle_l_y = 4'd13;
    pulse(10);
    checks++; if ({ball_x, ball_y} !== {4'd7, 4'd9}) begin errors++; $display("FAIL reserve_left got (%0d,%0d) want (7,9)", ball_x, ball_y); end
  endtask

  task automatic test_miss_right();
    pulse(70);
    checks++; if ({ball_x, ball_y} !== {4'd2, 4'd14}) begin errors++; $display("FAIL left_hit2 got (%0d,%0d) want (2,14)", ball_x, ball_y); end
    paddle_r_y = 4'd10;
    pulse(130);
    checks++; if ({score_l, score_r, point_l, point_r} !== {3'd1, 3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL miss_right got sl=%0d sr=%0d pl=%b pr=%b want 1 1 1 0", score_l, score_r, point_l, point_r); end
    checks++; if ({ball_x, ball_y} !== {4'd14, 4'd2}) begin errors++; $display("FAIL miss_right_frozen got (%0d,%0d) want (14,2)", ball_x, ball_y); end
    @(negedge clk);
    checks++; if (point_l !== 1'b0) begin errors++; $display("FAIL point_l_width got %b want 0", point_l); end
    pulse(100);
    paddle_r_y = 4'd0;
    pulse(10);
    checks++; if ({ball_x, ball_y} !== {4'd9, 4'd9}) begin errors++; $display("FAIL reserve_right got (%0d,%0d) want (9,9)", ball_x, ball_y); end
  endtask

  task automatic test_win();
    pulse(60);
    checks++; if ({score_l, ball_x, ball_y} !== {3'd2, 4'd14, 4'd14}) begin errors++; $display("FAIL point_2 got sl=%0d (%0d,%0d) want 2 (14,14)", score_l, ball_x, ball_y); end
    for (int p = 3; p <= 7; p++) begin
      pulse(170);
      checks++; if (score_l !== 3'(p)) begin errors++; $display("FAIL score_run got %0d want %0d", score_l, p); end
    end
    pulse(99);
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_early got %b want 0", game_over); end
    pulse(1);
    checks++; if ({game_over, score_l, score_r} !== {1'b1, 3'd7, 3'd1}) begin errors++; $display("FAIL game_over got go=%b sl=%0d sr=%0d want 1 7 1", game_over, score_l, score_r); end
    pulse(20);
    checks++; if ({ball_x, ball_y} !== {4'd14, 4'd14}) begin errors++; $display("FAIL over_frozen got (%0d,%0d) want (14,14)", ball_x, ball_y); end
    // start and a tick in the same cycle: start wins, step counter restarts
    @(negedge clk) begin start = 1'b1; clk_100Hz = 1'b1; end
    @(negedge clk) begin start = 1'b0; clk_100Hz = 1'b0; end
    checks++; if ({game_over, score_l, score_r, ball_x, ball_y} !== {1'b0, 3'd0, 3'd0, 4'd8, 4'd8}) begin errors++; $display("FAIL restart got go=%b sl=%0d sr=%0d (%0d,%0d) want 0 0 0 (8,8)", game_over, score_l, score_r, ball_x, ball_y); end
    pulse(9);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL restart_wait got (%0d,%0d) want (8,8)", ball_x, ball_y); end
    pulse(1);
    checks++; if ({ball_x, ball_y} !== {4'd7, 4'd9}) begin errors++; $display("FAIL restart_step got (%0d,%0d) want (7,9)", ball_x, ball_y); end
  endtask

  task automatic test_reset_mid();
    pulse(30);
    @(negedge clk) begin clk_100Hz = 1'b1; rst = 1'b0; end
    @(negedge clk);
    checks++; if ({ball_x, ball_y, score_l, score_r, point_l, point_r, game_over} !== {4'd8, 4'd8, 9'b0}) begin errors++; $display("FAIL reset_mid got (%0d,%0d) sl=%0d sr=%0d go=%b want (8,8) 0 0 0", ball_x, ball_y, score_l, score_r, game_over); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    press_start();
    repeat (4) @(negedge clk);
    clk_100Hz = 1'b0;
    pulse(9);
    checks++; if ({ball_x, ball_y} !== {4'd8, 4'd8}) begin errors++; $display("FAIL post_reset_wait got (%0d,%0d) want (8,8)", ball_x, ball_y); end
    pulse(1);
    checks++; if ({ball_x, ball_y} !== {4'd7, 4'd9}) begin errors++; $display("FAIL post_reset_step got (%0d,%0d) want (7,9)", ball_x, ball_y); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; clk_100Hz = 1'b0; start = 1'b0;
    paddle_l_y = 4'd0; paddle_r_y = 4'd0;
    test_reset();
    test_serve();
    test_rally();
    test_miss_left();
    test_miss_right();
    test_win();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
